// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one word-wide data_memory port between two requesters.
// Sub-word stores are turned into read-modify-write sequences.
module dmem_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic            req0_we,
    input  logic [AW-1:0]   req0_addr,
    input  logic [DW-1:0]   req0_wdata,
    input  logic [DW/8-1:0] req0_be,
    output logic            req0_rvalid,
    output logic [DW-1:0]   req0_rdata,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic            req1_we,
    input  logic [AW-1:0]   req1_addr,
    input  logic [DW-1:0]   req1_wdata,
    input  logic [DW/8-1:0] req1_be,
    output logic            req1_rvalid,
    output logic [DW-1:0]   req1_rdata,
    output logic [AW-1:0]   byte_address,
    output logic [DW-1:0]   write_data,
    output logic            MemWrite,
    output logic            MemRead,
    input  logic [DW-1:0]   output_data
);

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD,
        RESP,
        RMW_RD,
        RMW_WR
    } state_t;

    state_t state, next_state;

    logic            last_grant;
    logic            id_q;
    logic [AW-3:0]   addr_q;
    logic [DW-1:0]   wdata_q;
    logic [DW/8-1:0] be_q;

    logic            gnt0, gnt1, fire;
    logic            sel_we;
    logic [AW-3:0]   sel_addr;
    logic [DW-1:0]   sel_wdata;
    logic [DW/8-1:0] sel_be;
    logic [DW-1:0]   mask;
    logic            unused_lo;

    // Byte offset bits are ignored: memory is word addressed.
    assign unused_lo = ^{req0_addr[1:0], req1_addr[1:0]};

    // On a tie, the requester that did not win last time is granted.
    assign gnt0 = req0_valid && (!req1_valid || last_grant);
    assign gnt1 = req1_valid && (!req0_valid || !last_grant);

    assign req0_ready = (state == IDLE) && !rst && gnt0;
    assign req1_ready = (state == IDLE) && !rst && gnt1;
    assign fire       = req0_ready || req1_ready;

    assign sel_we    = req1_ready ? req1_we : req0_we;
    assign sel_addr  = req1_ready ? req1_addr[AW-1:2] : req0_addr[AW-1:2];
    assign sel_wdata = req1_ready ? req1_wdata : req0_wdata;
    assign sel_be    = req1_ready ? req1_be : req0_be;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            id_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
        end else begin
            state <= next_state;
            if (fire) begin
                last_grant <= req1_ready;
                id_q       <= req1_ready;
                addr_q     <= sel_addr;
                wdata_q    <= sel_wdata;
                be_q       <= sel_be;
            end
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (fire) begin
                    if (!sel_we)
                        next_state = RD;
                    else if (&sel_be || ~|sel_be)
                        next_state = WR;
                    else
                        next_state = RMW_RD;
                end
            end
            WR:     next_state = IDLE;
            RD:     next_state = RESP;
            RESP:   next_state = IDLE;
            RMW_RD: next_state = RMW_WR;
            RMW_WR: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        mask = '0;
        for (int i = 0; i < DW/8; i++)
            mask[8*i +: 8] = {8{be_q[i]}};
    end

    always_comb begin
        byte_address = '0;
        write_data   = '0;
        MemWrite     = 1'b0;
        MemRead      = 1'b0;
        req0_rvalid  = 1'b0;
        req1_rvalid  = 1'b0;
        req0_rdata   = '0;
        req1_rdata   = '0;
        unique case (state)
            WR: begin
                // An all-zero byte enable completes as a store without touching memory.
                if (|be_q) begin
                    MemWrite     = 1'b1;
                    byte_address = {addr_q, 2'b00};
                    write_data   = wdata_q;
                end
            end
            RD, RMW_RD: begin
                MemRead      = 1'b1;
                byte_address = {addr_q, 2'b00};
            end
            RESP: begin
                if (id_q) begin
                    req1_rvalid = 1'b1;
                    req1_rdata  = output_data;
                end else begin
                    req0_rvalid = 1'b1;
                    req0_rdata  = output_data;
                end
            end
            RMW_WR: begin
                MemWrite     = 1'b1;
                byte_address = {addr_q, 2'b00};
                write_data   = (output_data & ~mask) | (wdata_q & mask);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: word memory model plus a
// transaction-level reference memory predicting every load and store.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid = 0, req0_we = 0;
    logic [31:0] req0_addr = 0, req0_wdata = 0;
    logic [3:0]  req0_be = 0;
    logic        req0_ready, req0_rvalid;
    logic [31:0] req0_rdata;
    logic        req1_valid = 0, req1_we = 0;
    logic [31:0] req1_addr = 0, req1_wdata = 0;
    logic [3:0]  req1_be = 0;
    logic        req1_ready, req1_rvalid;
    logic [31:0] req1_rdata;
    logic [31:0] byte_address, write_data, output_data;
    logic        MemWrite, MemRead;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [0:1023];
    bit   [31:0] ref_mem [0:1023];

    always #5 clk = ~clk;

    dmem_arbiter #(.AW(32), .DW(32)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_we(req0_we), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata), .req0_be(req0_be),
        .req0_rvalid(req0_rvalid), .req0_rdata(req0_rdata),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_we(req1_we), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .req1_be(req1_be),
        .req1_rvalid(req1_rvalid), .req1_rdata(req1_rdata),
        .byte_address(byte_address), .write_data(write_data),
        .MemWrite(MemWrite), .MemRead(MemRead),
        .output_data(output_data)
    );

    always @(posedge clk) begin
        if (MemWrite) mem[byte_address[11:2]] <= write_data;
        if (MemRead) output_data <= mem[byte_address[11:2]];
    end

    always @(negedge clk) begin
        checks++;
        if (MemWrite && MemRead) begin
            errors++;
            $display("FAIL strobe_excl: MemWrite=%b MemRead=%b, required not both", MemWrite, MemRead);
        end
        checks++;
        if (!MemWrite && !MemRead && byte_address !== 0) begin
            errors++;
            $display("FAIL idle_addr: byte_address=%h with no strobe, required 0", byte_address);
        end
        checks++;
        if (!MemWrite && write_data !== 0) begin
            errors++;
            $display("FAIL idle_wdata: write_data=%h with MemWrite=0, required 0", write_data);
        end
    end

    function automatic logic [31:0] be_mask(input logic [3:0] be);
        logic [31:0] m;
        m = 0;
        for (int i = 0; i < 4; i++)
            if (be[i]) m[8*i +: 8] = 8'hFF;
        return m;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1;
        repeat (2) @(negedge clk);
        rst = 0;
    endtask

    task automatic xfer(input bit id, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be);
        logic [31:0] word, exp;
        bit got;
        int n;
        word = {addr[31:2], 2'b00};
        @(negedge clk);
        if (id) begin
            req1_valid = 1; req1_we = we; req1_addr = addr;
            req1_wdata = wdata; req1_be = be;
        end else begin
            req0_valid = 1; req0_we = we; req0_addr = addr;
            req0_wdata = wdata; req0_be = be;
        end
        got = 0;
        for (n = 0; n < 20; n++) begin
            #1;
            if (id ? req1_ready : req0_ready) begin
                got = 1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!got || n != 0) begin
            errors++;
            $display("FAIL accept id=%0d: ready after %0d cycles (got=%0d), required 0", id, n, got);
            if (!got) begin
                req0_valid = 0; req1_valid = 0;
                return;
            end
        end
        @(negedge clk);
        req0_valid = 0; req1_valid = 0;
        #1;
        if (!we) begin
            checks++;
            if (MemRead !== 1 || MemWrite !== 0 || byte_address !== word) begin
                errors++;
                $display("FAIL load_rd: rd=%b wr=%b addr=%h, required 1 0 %h", MemRead, MemWrite, byte_address, word);
            end
            @(negedge clk);
            #1;
            exp = ref_mem[word[11:2]];
            checks++;
            if ((id ? req1_rvalid : req0_rvalid) !== 1 || (id ? req0_rvalid : req1_rvalid) !== 0
                || (id ? req1_rdata : req0_rdata) !== exp) begin
                errors++;
                $display("FAIL load_resp id=%0d: rv0=%b rv1=%b rd0=%h rd1=%h, required data %h",
                         id, req0_rvalid, req1_rvalid, req0_rdata, req1_rdata, exp);
            end
        end else if (be == 4'hF || be == 4'h0) begin
            checks++;
            if (MemWrite !== (be != 0) || MemRead !== 0 || req0_rvalid !== 0 || req1_rvalid !== 0
                || (be != 0 && (byte_address !== word || write_data !== wdata))) begin
                errors++;
                $display("FAIL store_wr be=%h: wr=%b rd=%b addr=%h data=%h, required %b 0 %h %h",
                         be, MemWrite, MemRead, byte_address, write_data, be != 0, word, wdata);
            end
            if (be != 0) ref_mem[word[11:2]] = wdata;
        end else begin
            checks++;
            if (MemRead !== 1 || MemWrite !== 0 || byte_address !== word) begin
                errors++;
                $display("FAIL rmw_rd: rd=%b wr=%b addr=%h, required 1 0 %h", MemRead, MemWrite, byte_address, word);
            end
            exp = (ref_mem[word[11:2]] & ~be_mask(be)) | (wdata & be_mask(be));
            @(negedge clk);
            #1;
            checks++;
            if (MemWrite !== 1 || MemRead !== 0 || byte_address !== word || write_data !== exp
                || req0_rvalid !== 0 || req1_rvalid !== 0) begin
                errors++;
                $display("FAIL rmw_wr: wr=%b rd=%b addr=%h data=%h, required 1 0 %h %h",
                         MemWrite, MemRead, byte_address, write_data, word, exp);
            end
            ref_mem[word[11:2]] = exp;
        end
    endtask

    task automatic check_all_zero(input string tag);
        checks++;
        if ({req0_ready, req1_ready, req0_rvalid, req1_rvalid, MemWrite, MemRead} !== 0
            || req0_rdata !== 0 || req1_rdata !== 0 || byte_address !== 0 || write_data !== 0) begin
            errors++;
            $display("FAIL %s: rdy=%b%b rv=%b%b wr=%b rd=%b addr=%h wd=%h, required all 0", tag,
                     req0_ready, req1_ready, req0_rvalid, req1_rvalid, MemWrite, MemRead, byte_address, write_data);
        end
    endtask

    task automatic test_reset();
        rst = 1;
        repeat (3) @(negedge clk);
        #1;
        check_all_zero("reset_outputs");
        rst = 0;
    endtask

    task automatic test_store_load();
        xfer(0, 1, 32'h10, 32'hDEADBEEF, 4'hF);
        xfer(1, 0, 32'h10, 0, 0);
    endtask

    task automatic test_partial();
        xfer(0, 1, 32'h14, 32'h11223344, 4'hF);
        xfer(1, 1, 32'h14, 32'h0000AB00, 4'b0010);
        xfer(0, 0, 32'h14, 0, 0);
    endtask

    task automatic test_align_noop();
        xfer(0, 0, 32'h13, 0, 0);
        xfer(1, 1, 32'h10, 32'hFFFFFFFF, 4'h0);
        xfer(0, 0, 32'h10, 0, 0);
    endtask

    task automatic test_fill();
        for (int i = 0; i < 256; i++) xfer(1, 1, i * 4, i + 1, 4'hF);
        for (int i = 0; i < 256; i++) xfer(0, 0, i * 4, 0, 0);
    endtask

    task automatic test_random();
        for (int k = 0; k < 80; k++)
            xfer($urandom_range(0, 1), $urandom_range(0, 1),
                 $urandom_range(0, 255) * 4 + $urandom_range(0, 3),
                 $urandom, $urandom_range(0, 15));
    endtask

    task automatic test_arbitration();
        int i0, i1, cyc, last, expg;
        bit have_pend, pend_id, g;
        logic [31:0] pend_exp, d;
        do_reset();
        i0 = 0; i1 = 0; last = 1; have_pend = 0; pend_id = 0; pend_exp = 0;
        req0_we = 0; req1_we = 0; req0_be = 0; req1_be = 0;
        for (cyc = 0; cyc < 200 && (i0 < 6 || i1 < 6 || have_pend); cyc++) begin
            @(negedge clk);
            req0_valid = (i0 < 6);
            req0_addr = (i0 * 2) * 4;
            req1_valid = (i1 < 6);
            req1_addr = (i1 * 2 + 101) * 4;
            #1;
            if (req0_rvalid || req1_rvalid) begin
                checks++;
                d = req1_rvalid ? req1_rdata : req0_rdata;
                if (!have_pend || (req0_rvalid && req1_rvalid) || req1_rvalid != pend_id || d !== pend_exp) begin
                    errors++;
                    $display("FAIL route: rv0=%b rv1=%b data=%h, required id %0d data %h",
                             req0_rvalid, req1_rvalid, d, pend_id, pend_exp);
                end
                have_pend = 0;
            end
            if (req0_ready || req1_ready) begin
                g = req1_ready;
                expg = (req0_valid && req1_valid) ? (last ^ 1) : (req1_valid ? 1 : 0);
                checks++;
                if ((req0_ready && req1_ready) || g != expg || have_pend) begin
                    errors++;
                    $display("FAIL grant: rdy0=%b rdy1=%b pend=%b, required grant %0d", req0_ready, req1_ready, have_pend, expg);
                end
                last = g;
                pend_id = g;
                pend_exp = ref_mem[(g ? req1_addr : req0_addr) >> 2];
                have_pend = 1;
                if (g) i1++; else i0++;
            end
        end
        req0_valid = 0; req1_valid = 0;
        checks++;
        if (i0 != 6 || i1 != 6 || have_pend) begin
            errors++;
            $display("FAIL arb_timeout: grants %0d/%0d pend=%b, required 6/6 0", i0, i1, have_pend);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_rmw();
        @(negedge clk);
        req0_valid = 1; req0_we = 1; req0_addr = 32'h20;
        req0_wdata = 32'h000000FF; req0_be = 4'b0001;
        #1;
        checks++;
        if (req0_ready !== 1) begin
            errors++;
            $display("FAIL rmw_accept: ready=%b, required 1", req0_ready);
        end
        @(negedge clk);
        req0_valid = 0;
        rst = 1;
        #1;
        checks++;
        if (MemRead !== 1) begin
            errors++;
            $display("FAIL rmw_pre_reset: MemRead=%b, required 1", MemRead);
        end
        @(negedge clk);
        #1;
        check_all_zero("mid_reset_outputs");
        @(negedge clk);
        rst = 0;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (MemWrite !== 0) begin
                errors++;
                $display("FAIL rmw_aborted: MemWrite=%b, required 0", MemWrite);
            end
            @(negedge clk);
        end
        req0_valid = 1; req0_we = 0; req0_addr = 32'h20;
        req1_valid = 1; req1_we = 0; req1_addr = 32'h20;
        #1;
        checks++;
        if (req0_ready !== 1 || req1_ready !== 0) begin
            errors++;
            $display("FAIL tie_after_reset: rdy0=%b rdy1=%b, required 1 0", req0_ready, req1_ready);
        end
        @(negedge clk);
        req0_valid = 0; req1_valid = 0;
        @(negedge clk);
        xfer(1, 0, 32'h20, 0, 0);
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_partial();
        test_align_noop();
        test_fill();
        test_arbitration();
        test_random();
        test_reset_mid_rmw();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
